// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the seven-segment display controller.
// Glyph codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph lookup, active-low {g,f,e,d,c,b,a}.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);
  always_comb begin
    seg = SEG_BLANK;
    unique case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_display_ctrl.sv
// N-digit seven-segment controller: hex or double-dabble decimal view with
// leading-zero blanking, per-digit blink and overflow dashes.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       value_i,
  input  logic                    load_i,
  input  logic                    mode_dec_i,
  input  logic                    blank_lz_i,
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [7*NUM_DIGITS-1:0] seg_o
);
  localparam int   BW      = 4*NUM_DIGITS;
  localparam int   CW      = $clog2(DATA_W+1);
  localparam int   BCW     = $clog2(BLINK_DIV);
  localparam seg_t SEG_OFF = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  state_t                       state_q, state_d;
  logic [DATA_W-1:0]            sh_q;
  logic                         mode_q;
  logic [BW-1:0]                bcd_q, bcd_adj, bcd_nxt;
  logic                         bcd_ovf_q;
  logic [CW-1:0]                it_q;
  logic [NUM_DIGITS-1:0][3:0]   disp_q;
  logic                         disp_ovf_q, disp_vld_q;
  logic [BCW-1:0]               bcnt_q;
  logic                         hidden_q;
  logic [BW-1:0]                hex_dig;
  logic                         hex_ovf;
  logic [NUM_DIGITS-1:0]        zero_up;
  logic [NUM_DIGITS-1:0][6:0]   glyph, seg_d, seg_q;

  assign busy_o     = (state_q != IDLE);
  assign overflow_o = disp_ovf_q;
  assign seg_o      = seg_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_i) state_d = mode_dec_i ? SHIFT : COMMIT;
      SHIFT:   if (it_q == CW'(DATA_W-1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add-3 on every BCD nibble >= 5, then shift in the next value bit
  always_comb begin
    bcd_adj = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3
                                                    : bcd_q[4*k +: 4];
  end
  assign bcd_nxt = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};

  generate
    if (DATA_W > BW) begin : g_hex_trunc
      assign hex_dig = sh_q[BW-1:0];
      assign hex_ovf = |sh_q[DATA_W-1:BW];
    end else if (DATA_W == BW) begin : g_hex_exact
      assign hex_dig = sh_q;
      assign hex_ovf = 1'b0;
    end else begin : g_hex_ext
      assign hex_dig = {{(BW-DATA_W){1'b0}}, sh_q};
      assign hex_ovf = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      mode_q     <= 1'b0;
      bcd_q      <= '0;
      bcd_ovf_q  <= 1'b0;
      it_q       <= '0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      disp_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (load_i) begin
          sh_q      <= value_i;
          mode_q    <= mode_dec_i;
          bcd_q     <= '0;
          bcd_ovf_q <= 1'b0;
          it_q      <= '0;
        end
        SHIFT: begin
          bcd_q     <= bcd_nxt;
          bcd_ovf_q <= bcd_ovf_q | bcd_adj[BW-1];
          sh_q      <= sh_q << 1;
          it_q      <= it_q + CW'(1);
        end
        COMMIT: begin
          disp_q     <= mode_q ? bcd_q : hex_dig;
          disp_ovf_q <= mode_q ? bcd_ovf_q : hex_ovf;
          disp_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q   <= '0;
      hidden_q <= 1'b0;
    end else if (bcnt_q == BCW'(BLINK_DIV-1)) begin
      bcnt_q   <= '0;
      hidden_q <= ~hidden_q;
    end else begin
      bcnt_q   <= bcnt_q + BCW'(1);
    end
  end

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      seg7_glyph u_glyph (.nib(disp_q[g]), .seg(glyph[g]));
    end
  endgenerate

  // zero_up[k]: digit k and every digit above it are zero
  always_comb begin
    zero_up = '0;
    zero_up[NUM_DIGITS-1] = (disp_q[NUM_DIGITS-1] == 4'h0);
    for (int k = NUM_DIGITS-2; k >= 0; k--)
      zero_up[k] = zero_up[k+1] & (disp_q[k] == 4'h0);
  end

  always_comb begin
    seg_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!disp_vld_q)                            seg_d[k] = SEG_BLANK;
      else if (disp_ovf_q)                        seg_d[k] = SEG_DASH;
      else if (blank_lz_i && k != 0 && zero_up[k]) seg_d[k] = SEG_BLANK;
      else                                        seg_d[k] = glyph[k];
      if (hidden_q && blink_mask_i[k])            seg_d[k] = SEG_BLANK;
      if (!ACTIVE_LOW)                            seg_d[k] = ~seg_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) seg_q <= {NUM_DIGITS{SEG_OFF}};
    else     seg_q <= seg_d;
  end
endmodule
